// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes packed hex nibbles onto one seven_seg decoder,
// with per-slot anti-ghost guard time, leading-zero blanking and a per-frame value latch.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic                          blank_lz,
    output logic [3:0]                    digit,
    output logic                          enable,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

    state_t                  state;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [3:0]              nib;
    logic                    blank;
    logic                    slot_end;
    logic                    last;

    // a digit is a leading zero when it and every digit above it are zero
    assign nib      = shadow[4*idx +: 4];
    assign blank    = blank_lz && idx != '0 && (shadow >> (4*idx)) == '0;
    assign slot_end = presc == PW'(REFRESH_DIV-1);
    assign last     = idx == IW'(NUM_DIGITS-1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            idx        <= '0;
            shadow     <= '0;
            digit      <= '0;
            enable     <= 1'b0;
            anode_n    <= '1;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else if (!run) begin
            state      <= IDLE;
            digit      <= '0;
            enable     <= 1'b0;
            anode_n    <= '1;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            enable     <= 1'b0;
            anode_n    <= '1;
            digit      <= nib;
            digit_idx  <= idx;
            case (state)
                IDLE: begin
                    state     <= GUARD;
                    presc     <= '0;
                    idx       <= '0;
                    shadow    <= value;
                    digit     <= '0;
                    digit_idx <= '0;
                end
                GUARD: begin
                    presc <= presc + 1'b1;
                    if (presc == PW'(GUARD_CYCLES-1)) state <= SHOW;
                end
                SHOW: begin
                    anode_n <= ~(NUM_DIGITS'(1) << idx);
                    enable  <= !blank;
                    if (slot_end) begin
                        state <= GUARD;
                        presc <= '0;
                        idx   <= last ? '0 : idx + 1'b1;
                        if (last) begin
                            frame_done <= 1'b1;
                            shadow     <= value;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
